// File: rtl/dec_onehot_pipe.sv
// Registered select-code decoder (one-hot or thermometer) with a valid/ready
// handshake and a two-entry output buffer (output register plus skid register).
module dec_onehot_pipe #(
    parameter int SEL_W      = 3,
    parameter int OUT_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             thermo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             out_err,
    output logic             err_sticky
);

    typedef struct packed {
        logic [OUT_W-1:0] pat;
        logic             err;
    } word_t;

    localparam logic [OUT_W-1:0] IDLE   = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam word_t            IDLE_W = '{pat: IDLE, err: 1'b0};

    logic [31:0]      sel_ext;
    logic             in_range;
    logic [OUT_W-1:0] hot;
    word_t            dec_w;

    assign sel_ext  = 32'(sel);
    assign in_range = sel_ext < 32'(OUT_W);

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign hot[i] = thermo ? (sel_ext >= 32'(i)) : (sel_ext == 32'(i));
    end

    // Polarity is applied to the final pattern only; the error flag stays true-high.
    always_comb begin
        dec_w.err = en & ~in_range;
        dec_w.pat = ((en & in_range) ? hot : {OUT_W{1'b0}}) ^ {OUT_W{ACTIVE_LOW}};
    end

    word_t out_q, skid_q;
    logic  out_vld, skid_vld, sticky;
    logic  accept, pop;

    assign accept = in_valid & ~skid_vld;
    assign pop    = out_vld & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= IDLE_W;
            skid_q   <= IDLE_W;
            sticky   <= 1'b0;
        end else begin
            if (accept & dec_w.err)
                sticky <= 1'b1;
            // A full skid implies in_ready was low, so no accept competes with the refill.
            if (pop & skid_vld) begin
                out_q    <= skid_q;
                skid_vld <= 1'b0;
            end else if (accept & (~out_vld | pop)) begin
                out_q   <= dec_w;
                out_vld <= 1'b1;
            end else if (accept) begin
                skid_q   <= dec_w;
                skid_vld <= 1'b1;
            end else if (pop) begin
                out_q   <= IDLE_W;
                out_vld <= 1'b0;
            end
        end
    end

    assign in_ready   = ~skid_vld;
    assign out_valid  = out_vld;
    assign dout       = out_q.pat;
    assign out_err    = out_q.err;
    assign err_sticky = sticky;

endmodule

// File: tb/tb_dec_onehot_pipe.sv
// Randomised and directed bench for dec_onehot_pipe: three instances (default,
// active-low, OUT_W=6) share one input stream and are checked against a FIFO model.
module tb_dec_onehot_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, en = 1'b0, thermo = 1'b0, out_ready = 1'b0;
    logic [2:0] sel = '0;

    logic       ir_a, ov_a, er_a, st_a;
    logic       ir_l, ov_l, er_l, st_l;
    logic       ir_r, ov_r, er_r, st_r;
    logic [7:0] do_a, do_l;
    logic [5:0] do_r;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dec_onehot_pipe #(.SEL_W(3), .OUT_W(8), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .sel(sel),
        .en(en), .thermo(thermo), .out_valid(ov_a), .out_ready(out_ready),
        .dout(do_a), .out_err(er_a), .err_sticky(st_a));

    dec_onehot_pipe #(.SEL_W(3), .OUT_W(8), .ACTIVE_LOW(1'b1)) u_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_l), .sel(sel),
        .en(en), .thermo(thermo), .out_valid(ov_l), .out_ready(out_ready),
        .dout(do_l), .out_err(er_l), .err_sticky(st_l));

    dec_onehot_pipe #(.SEL_W(3), .OUT_W(6), .ACTIVE_LOW(1'b0)) u_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_r), .sel(sel),
        .en(en), .thermo(thermo), .out_valid(ov_r), .out_ready(out_ready),
        .dout(do_r), .out_err(er_r), .err_sticky(st_r));

    // Reference: words held by the block, oldest first (capacity two).
    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       thermo;
    } word_t;

    word_t q[$];
    logic  ms_a = 1'b0, ms_l = 1'b0, ms_r = 1'b0;

    function automatic logic err_m(input word_t w, input int ow);
        return w.en && (int'(w.sel) >= ow);
    endfunction

    function automatic logic [7:0] dec_m(input word_t w, input int ow, input bit al);
        int v;
        if (!w.en || int'(w.sel) >= ow) v = 0;
        else if (w.thermo)              v = (1 << (w.sel + 1)) - 1;
        else                            v = 1 << w.sel;
        if (al) v = ~v & ((1 << ow) - 1);
        return v[7:0];
    endfunction

    function automatic logic [33:0] exp_vec();
        word_t      w;
        logic       has, ir;
        logic [7:0] pa, pl, pr;
        has = q.size() > 0;
        ir  = q.size() < 2;
        w   = has ? q[0] : word_t'(0);
        pa  = dec_m(w, 8, 1'b0);
        pl  = dec_m(w, 8, 1'b1);
        pr  = dec_m(w, 6, 1'b0);
        return {has, ir, pa, err_m(w, 8), ms_a,
                has, ir, pl, err_m(w, 8), ms_l,
                has, ir, pr[5:0], err_m(w, 6), ms_r};
    endfunction

    function automatic logic [33:0] obs_vec();
        return {ov_a, ir_a, do_a, er_a, st_a,
                ov_l, ir_l, do_l, er_l, st_l,
                ov_r, ir_r, do_r, er_r, st_r};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic v, input logic [2:0] s, input logic e, input logic t,
                        input logic r);
        word_t w;
        logic  acc, pp;
        in_valid = v; sel = s; en = e; thermo = t; out_ready = r;
        acc = v && (q.size() < 2);
        pp  = (q.size() > 0) && r;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            ms_a = 1'b0; ms_l = 1'b0; ms_r = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                w = '{sel: s, en: e, thermo: t};
                q.push_back(w);
                ms_a = ms_a | err_m(w, 8);
                ms_l = ms_l | err_m(w, 8);
                ms_r = ms_r | err_m(w, 6);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({ov_l, ir_l, do_l, do_a, st_a} !== {1'b0, 1'b1, 8'hFF, 8'h00, 1'b0}) begin
            errors++; $display("FAIL reset_idle: got ov=%b ir=%b dl=%h da=%h st=%b want 0 1 ff 00 0",
                               ov_l, ir_l, do_l, do_a, st_a);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] one;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 1'b1, 1'b0, 1'b1);
            one = 8'h01 << i;
            checks++;
            if (obs_vec() !== exp_vec() || do_a !== one || ov_a !== 1'b1) begin
                errors++; $display("FAIL sweep[%0d]: got %h dout=%h ov=%b want %h dout=%h ov=1",
                                   i, obs_vec(), do_a, ov_a, exp_vec(), one);
            end
        end
    endtask

    task automatic test_thermo();
        logic [2:0] sv [3];
        logic [7:0] ev [3];
        sv = '{3'd0, 3'd3, 3'd7};
        ev = '{8'h01, 8'h0F, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, sv[i], 1'b1, 1'b1, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec() || do_a !== ev[i]) begin
                errors++; $display("FAIL thermo[%0d]: got %h dout=%h want %h dout=%h",
                                   i, obs_vec(), do_a, exp_vec(), ev[i]);
            end
        end
    endtask

    task automatic test_polarity();
        step(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || do_l !== 8'hFB) begin
            errors++; $display("FAIL pol_sel2: got %h dout=%h want %h dout=fb", obs_vec(), do_l, exp_vec());
        end
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || do_l !== 8'hFF || er_l !== 1'b0 || ov_l !== 1'b1) begin
            errors++; $display("FAIL pol_en0: got %h dout=%h err=%b want %h dout=ff err=0",
                               obs_vec(), do_l, er_l, exp_vec());
        end
    endtask

    task automatic test_range();
        step(1'b1, 3'd6, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || {do_r, er_r, st_r, st_a} !== {6'h00, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL range_oor: got %h dout=%h err=%b st=%b want %h dout=00 err=1 st=1",
                               obs_vec(), do_r, er_r, st_r, exp_vec());
        end
        step(1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || {do_r, er_r, st_r} !== {6'h02, 1'b0, 1'b1}) begin
            errors++; $display("FAIL range_next: got %h dout=%h err=%b st=%b want %h dout=02 err=0 st=1",
                               obs_vec(), do_r, er_r, st_r, exp_vec());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ev [3];
        ev = '{8'h04, 8'h08, 8'h00};
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || {ov_a, ir_a, do_a} !== {1'b1, 1'b0, 8'h02}) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h ov=%b ir=%b dout=%h want %h ov=1 ir=0 dout=02",
                                   i, obs_vec(), ov_a, ir_a, do_a, exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(i < 2, 3'd3, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec() || do_a !== ev[i] || ov_a !== (i < 2)) begin
                errors++; $display("FAIL bp_drain[%0d]: got %h dout=%h ov=%b want %h dout=%h",
                                   i, obs_vec(), do_a, ov_a, exp_vec(), ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || {ir_a, st_r} !== 2'b01) begin
            errors++; $display("FAIL mid_full: got %h ir=%b st=%b want %h ir=0 st=1",
                               obs_vec(), ir_a, st_r, exp_vec());
        end
        rst_n = 1'b0;
        step(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        checks++;
        if (obs_vec() !== exp_vec() || {ov_a, ir_a, st_r, do_l, do_a} !== {3'b010, 8'hFF, 8'h00}) begin
            errors++; $display("FAIL mid_reset: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || ov_a !== 1'b0) begin
            errors++; $display("FAIL mid_after: got %h ov=%b want %h ov=0", obs_vec(), ov_a, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sweep();
        test_thermo();
        test_polarity();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_onehot_pipe.md
Name: dec_onehot_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3-to-8 combinational decoder.
- Decodes a SEL_W-bit select code into an OUT_W-bit output pattern; mode is one-hot or thermometer, polarity is active-high or active-low.
- Valid/ready handshake on both sides, with a 2-entry output buffer (output register plus skid register), so it runs at full throughput under backpressure.
- Used on register-file write-enable and memory-bank-select paths where the decode must be registered.

Parameters:
- SEL_W, 3, width of the select code; legal range 1..6.
- OUT_W, 8, output width; legal range 2..2**SEL_W. Select codes >= OUT_W are out-of-range.
- ACTIVE_LOW, 0, 1 = all output bits inverted, so active bits are 0 and the idle pattern is all 1s.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- sel  in  SEL_W  select code.
- en  in  1  decode enable; 0 forces the idle pattern for this word.
- thermo  in  1  0 = one-hot, 1 = thermometer (bits 0..sel active).
- out_valid  out  1  dout/out_err hold a valid word.
- out_ready  in  1  downstream accepts the word.
- dout  out  OUT_W  decoded pattern.
- out_err  out  1  word had en=1 and sel >= OUT_W.
- err_sticky  out  1  set by any accepted out-of-range word; cleared only by reset.

Behaviour:
- Reset: one clk edge with rst_n=0 sets:
  - out_valid=0, skid_valid=0, out_err=0, err_sticky=0.
  - dout = idle pattern: all 0 if ACTIVE_LOW=0, all 1 if ACTIVE_LOW=1.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer discards both buffered words; no partial output.
- in_ready = ~skid_valid, driven from a register with no combinational path from out_ready. Accept occurs when in_valid & in_ready at a clk edge.
- Decode function (evaluated on the accepted word):
  - en=0: pattern = idle, err=0.
  - en=1, sel >= OUT_W: pattern = idle, err=1.
  - thermo=0: bit sel active, all others inactive.
  - thermo=1: bits 0..sel active. sel=0 gives only bit 0; sel=OUT_W-1 gives all bits active.
  - ACTIVE_LOW inverts the final pattern only. err is never inverted.
- Latency: a word accepted at edge k appears on dout with out_valid=1 after edge k, when the output register is empty or draining.
- Buffer rules at each edge, with pop = out_valid & out_ready:
  - accept & (~out_valid | pop) & ~skid_valid: word goes to the output register.
  - accept & out_valid & ~pop: word goes to the skid register; skid_valid=1, so in_ready=0 next cycle.
  - pop & skid_valid: skid word moves to the output register; skid_valid=0.
  - pop, no skid word, no accept: out_valid=0; dout returns to idle.
  - Simultaneous accept and pop with an empty skid: the new word replaces the popped word, and out_valid stays 1.
- Ordering is strict FIFO. No word is dropped or duplicated.
- While out_valid=1 & out_ready=0, dout and out_err hold stable.
- err_sticky is set on the edge that accepts an out-of-range word, not the edge that outputs it.
- sel/en/thermo are ignored when no accept occurs.

Test Plan:
- Exhaustive sweep, defaults (SEL_W=3, OUT_W=8, ACTIVE_LOW=0), out_ready=1, en=1, thermo=0:
  - sel=0..7 on back-to-back cycles -> dout=01,02,04,...,80 hex, one cycle after each accept.
  - out_valid stays 1 continuously; no bubbles.
- Thermometer, same parameters, thermo=1:
  - sel=0 -> dout=01; sel=3 -> 0F; sel=7 -> FF.
- Polarity and enable, ACTIVE_LOW=1:
  - sel=2, en=1, thermo=0 -> dout=FB.
  - en=0 -> dout=FF with out_err=0.
  - After reset, dout=FF and out_valid=0.
- Range error, OUT_W=6, SEL_W=3:
  - sel=6, en=1 -> dout=00, out_err=1, err_sticky=1 from the accepting edge.
  - Following sel=1 -> dout=02, out_err=0, err_sticky remains 1.
- Backpressure:
  - Send sel=1,2,3 with out_ready=0 -> sel=1 in the output register, sel=2 in skid, in_ready=0, sel=3 held upstream.
  - Raise out_ready -> outputs 02,04,08 in order, with no loss or duplication.
- Reset mid-stream: assert rst_n=0 for one edge with both buffers full -> next cycle out_valid=0, in_ready=1, err_sticky=0, dout=idle.
